// File: rtl/vga_scaled_reader_if.sv
// Read-port bus between the VGA scaled reader and the frame buffer RAM.
// The reader drives the address; the RAM returns data RAM_LAT cycles later.
interface vga_scaled_reader_if #(
   parameter int AW = 15,
   parameter int DW = 12
);
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;

   modport master (output ram_addr, input ram_data);
   modport slave  (input ram_addr, output ram_data);
endinterface

// File: rtl/vga_scaled_reader.sv
// VGA timing generator that reads an IMG_W x IMG_H frame buffer with 1x/2x/4x
// integer upscaling. Sync, flags and pixel data leave the block pipeline-aligned.
module vga_scaled_reader #(
   parameter int AW       = 15,
   parameter int DW       = 12,
   parameter int IMG_W    = 160,
   parameter int IMG_H    = 120,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RAM_LAT  = 1,
   parameter logic [DW-1:0] BORDER = 12'h000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          scale,
   vga_scaled_reader_if.master ram,
   output logic [DW-1:0]       pixel_out,
   output logic                hsync_n,
   output logic                vsync_n,
   output logic                frame_start,
   output logic [9:0]          pos_x,
   output logic [9:0]          pos_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [11:0] WX1 = 12'(IMG_W);
   localparam logic [11:0] WX2 = 12'(IMG_W * 2);
   localparam logic [11:0] WX4 = 12'(IMG_W * 4);
   localparam logic [11:0] WY1 = 12'(IMG_H);
   localparam logic [11:0] WY2 = 12'(IMG_H * 2);
   localparam logic [11:0] WY4 = 12'(IMG_H * 4);

   localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);
   localparam logic [AW-1:0] SENTINEL = AW'(IMG_W * IMG_H);

   localparam logic [1:0] SCALE_1X = 2'b00;
   localparam logic [1:0] SCALE_2X = 2'b01;

   logic [9:0]    h, v;
   logic [1:0]    s_lat;
   logic [1:0]    sub_max;
   logic [1:0]    xsub, ysub;
   logic [AW-1:0] xsrc, row_base;
   logic [11:0]   wx_lim, wy_lim;
   logic          last_h, last_v;
   logic          active_now, window_now, hs_now, vs_now, fs_now;

   logic [RAM_LAT:0] act_d, win_d, hs_d, vs_d, fs_d;

   assign last_h = (h == H_LAST);
   assign last_v = (v == V_LAST);
   assign pos_x  = h;
   assign pos_y  = v;

   // Decode the latched scale into sub-counter wrap value and window extents,
   // and derive the undelayed per-position flags from the counters.
   always_comb begin
      sub_max = 2'd3;
      wx_lim  = WX4;
      wy_lim  = WY4;
      case (s_lat)
         SCALE_1X: begin sub_max = 2'd0; wx_lim = WX1; wy_lim = WY1; end
         SCALE_2X: begin sub_max = 2'd1; wx_lim = WX2; wy_lim = WY2; end
         default:  begin sub_max = 2'd3; wx_lim = WX4; wy_lim = WY4; end
      endcase
      active_now = (h < H_ACT) && (v < V_ACT);
      window_now = active_now && ({2'b00, h} < wx_lim) && ({2'b00, v} < wy_lim);
      hs_now     = (h >= HS_FIRST) && (h <= HS_LAST);
      vs_now     = (v >= VS_FIRST) && (v <= VS_LAST);
      fs_now     = (h == 10'd0) && (v == 10'd0);
   end

   // Raster counters; the scale only changes on the last pixel of a frame so a
   // whole frame is always drawn with one factor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h     <= '0;
         v     <= '0;
         s_lat <= SCALE_1X;
      end else begin
         if (last_h) begin
            h <= '0;
            v <= last_v ? 10'd0 : v + 10'd1;
            if (last_v) s_lat <= scale;
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   // Horizontal source column: advance once every s pixels, restart each line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xsub <= '0;
         xsrc <= '0;
      end else if (last_h) begin
         xsub <= '0;
         xsrc <= '0;
      end else if (xsub == sub_max) begin
         xsub <= '0;
         xsrc <= xsrc + AW'(1);
      end else begin
         xsub <= xsub + 2'd1;
      end
   end

   // Vertical source row base: step by one stored line every s display lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ysub     <= '0;
         row_base <= '0;
      end else if (last_h) begin
         if (last_v) begin
            ysub     <= '0;
            row_base <= '0;
         end else if (ysub == sub_max) begin
            ysub     <= '0;
            row_base <= row_base + IMG_W_A;
         end else begin
            ysub <= ysub + 2'd1;
         end
      end
   end

   // Registered read address; outside the window point at the sentinel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ram.ram_addr <= '0;
      else     ram.ram_addr <= window_now ? (row_base + xsrc) : SENTINEL;
   end

   // Carry the position flags alongside the RAM access so they meet ram_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_d <= '0;
         win_d <= '0;
         hs_d  <= '0;
         vs_d  <= '0;
         fs_d  <= '0;
      end else begin
         for (int i = RAM_LAT; i > 0; i--) begin
            act_d[i] <= act_d[i-1];
            win_d[i] <= win_d[i-1];
            hs_d[i]  <= hs_d[i-1];
            vs_d[i]  <= vs_d[i-1];
            fs_d[i]  <= fs_d[i-1];
         end
         act_d[0] <= active_now;
         win_d[0] <= window_now;
         hs_d[0]  <= hs_now;
         vs_d[0]  <= vs_now;
         fs_d[0]  <= fs_now;
      end
   end

   // Final output register: pick image, border or black and drive the syncs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_out   <= '0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         pixel_out   <= win_d[RAM_LAT] ? ram.ram_data :
                        (act_d[RAM_LAT] ? BORDER : '0);
         hsync_n     <= ~hs_d[RAM_LAT];
         vsync_n     <= ~vs_d[RAM_LAT];
         frame_start <= fs_d[RAM_LAT];
      end
   end

endmodule

// File: tb/tb_vga_scaled_reader.sv
// Randomised scoreboard bench for vga_scaled_reader using a shrunken raster so
// that several whole frames (and the frame-boundary scale latch) fit in a short run.
module tb_vga_scaled_reader;

   localparam int AW       = 15;
   localparam int DW       = 12;
   localparam int IMG_W    = 12;
   localparam int IMG_H    = 8;
   localparam int H_ACTIVE = 40;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 6;
   localparam int H_BP     = 6;
   localparam int V_ACTIVE = 30;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int RAM_LAT  = 1;
   localparam logic [DW-1:0] BORDER = 12'hF0F;
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int L  = RAM_LAT + 2;

   typedef struct {
      int            h;
      int            v;
      logic [DW-1:0] pix;
      logic          hs_n;
      logic          vs_n;
      logic          fs;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    scale = 2'b00;
   logic [DW-1:0] pixel_out;
   logic          hsync_n, vsync_n, frame_start;
   logic [9:0]    pos_x, pos_y;

   int checks = 0;
   int passes = 0;
   int pos_n = 0;
   int cur_code = 0;
   int fidx = 0;
   int plan [6] = '{1, 2, 3, 0, 2, 1};

   exp_t pix_q [$];
   int   addr_q [$];

   vga_scaled_reader_if #(.AW(AW), .DW(DW)) ram_bus ();

   vga_scaled_reader #(
      .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .RAM_LAT(RAM_LAT), .BORDER(BORDER)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scale       (scale),
      .ram         (ram_bus),
      .pixel_out   (pixel_out),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .frame_start (frame_start),
      .pos_x       (pos_x),
      .pos_y       (pos_y)
   );

   always #5 clk = ~clk;

   // Frame buffer stand-in: one-cycle read, content is the low 11 address bits.
   always @(posedge clk) ram_bus.ram_data <= {1'b0, ram_bus.ram_addr[10:0]};

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // What the screen should show at raster position (h,v) for a given scale code.
   function automatic exp_t model_pixel(input int h, input int v, input int code,
                                        output int addr);
      exp_t e;
      int   s;
      bit   act, win;
      s    = (code == 0) ? 1 : ((code == 1) ? 2 : 4);
      act  = (h < H_ACTIVE) && (v < V_ACTIVE);
      win  = act && (h < IMG_W * s) && (v < IMG_H * s);
      addr = win ? (v / s) * IMG_W + (h / s) : IMG_W * IMG_H;
      e.h    = h;
      e.v    = v;
      e.pix  = !act ? '0 : (win ? DW'(addr % 2048) : BORDER);
      e.hs_n = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      e.vs_n = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
      e.fs   = (h == 0) && (v == 0);
      return e;
   endfunction

   task automatic check_reset_values(input string tag);
      check_output({tag, "_pixel_out"}, int'(pixel_out), 0);
      check_output({tag, "_hsync_n"}, int'(hsync_n), 1);
      check_output({tag, "_vsync_n"}, int'(vsync_n), 1);
      check_output({tag, "_frame_start"}, int'(frame_start), 0);
      check_output({tag, "_ram_addr"}, int'(ram_bus.ram_addr), 0);
      check_output({tag, "_pos_x"}, int'(pos_x), 0);
      check_output({tag, "_pos_y"}, int'(pos_y), 0);
   endtask

   // Drive one cycle per raster position and push the expected response.
   task automatic apply_stimulus(input int n_cycles);
      exp_t e;
      int   a, h, v;
      for (int i = 0; i < n_cycles; i++) begin
         h = pos_n % HT;
         v = (pos_n / HT) % VT;
         if (v > 0 && v < VT - 3 && $urandom_range(0, 59) == 0)
            scale = 2'($urandom_range(0, 3));
         if (h == 0 && v == VT - 3)
            scale = 2'(plan[fidx % 6]);
         check_output("pos_x", int'(pos_x), h);
         check_output("pos_y", int'(pos_y), v);
         e = model_pixel(h, v, cur_code, a);
         pix_q.push_back(e);
         addr_q.push_back(a);
         if (h == HT - 1 && v == VT - 1) begin
            cur_code = int'(scale);
            fidx++;
         end
         pos_n++;
         @(negedge clk);
      end
   endtask

   task automatic restart_model();
      pix_q.delete();
      addr_q.delete();
      pos_n    = 0;
      cur_code = 0;
   endtask

   // Monitor: compare whatever the DUT presents after each edge with the queues.
   always begin
      exp_t e;
      int   a;
      @(posedge clk);
      #2;
      if (!rst) begin
         if (addr_q.size() == 0) begin
            check_output("addr_q_underflow", addr_q.size(), 1);
         end else begin
            a = addr_q.pop_front();
            check_output("ram_addr", int'(ram_bus.ram_addr), a);
         end
         if (pix_q.size() >= L) begin
            e = pix_q.pop_front();
            check_output($sformatf("pixel_out(%0d,%0d)", e.h, e.v), int'(pixel_out), int'(e.pix));
            check_output($sformatf("hsync_n(%0d,%0d)", e.h, e.v), int'(hsync_n), int'(e.hs_n));
            check_output($sformatf("vsync_n(%0d,%0d)", e.h, e.v), int'(vsync_n), int'(e.vs_n));
            check_output($sformatf("frame_start(%0d,%0d)", e.h, e.v), int'(frame_start), int'(e.fs));
         end else begin
            check_output("fill_pixel_out", int'(pixel_out), 0);
            check_output("fill_hsync_n", int'(hsync_n), 1);
            check_output("fill_vsync_n", int'(vsync_n), 1);
            check_output("fill_frame_start", int'(frame_start), 0);
         end
      end
   end

   initial begin
      $display("[TB] start");
      scale = 2'b10;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      restart_model();
      rst = 1'b0;
      apply_stimulus(6 * HT * VT);

      apply_stimulus(2 * HT * VT + 10 * HT + 30);
      #1;
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      @(negedge clk);
      check_reset_values("midrst_hold");
      restart_model();
      rst = 1'b0;
      apply_stimulus(2 * HT * VT + 20);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
